// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one fixed-latency memory.
// Optional MEM_ARB_MISALIGN_CHECK_EN flags misaligned data accesses.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_write,
  input  logic [1:0]  d_req_size,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [2:0]  lat_cnt;
  logic [3:0]  starve_cnt;
  logic        gnt_d_q;
  logic        write_q;
  logic        misal_q;
  logic [1:0]  lo_q;
  logic [1:0]  size_q;

  logic        can_acc;
  logic        starved;
  logic        if_acc;
  logic        d_acc;
  logic [31:0] req_addr;
  logic [3:0]  be_d;
  logic [31:0] wd_d;
  logic        misal_d;
  logic [31:0] sh_d;
  logic [31:0] ld_d;

  // Ready is gated by reset so no requester sees an ignored acceptance.
  assign can_acc = reset && (state == IDLE || state == RESP);
  assign starved = starve_cnt == 4'(STARVE_LIMIT);

  assign if_req_ready = can_acc && if_req_valid &&
                        (!d_req_valid || starved);
  assign d_req_ready  = can_acc && d_req_valid &&
                        !(if_req_valid && starved);

  assign if_acc   = if_req_valid && if_req_ready;
  assign d_acc    = d_req_valid && d_req_ready;
  assign req_addr = d_acc ? d_req_addr : if_req_addr;

  always_comb begin
    be_d = 4'b1111;
    wd_d = d_req_wdata;
    case (d_req_size)
      2'd0: begin
        be_d = 4'b0001 << d_req_addr[1:0];
        wd_d = {4{d_req_wdata[7:0]}};
      end
      2'd1: begin
        be_d = 4'b0011 << {d_req_addr[1], 1'b0};
        wd_d = {2{d_req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_MISALIGN_CHECK_EN
  assign misal_d = (d_req_size == 2'd3) ||
                   (d_req_size == 2'd1 && d_req_addr[0]) ||
                   (d_req_size == 2'd2 && d_req_addr[1:0] != 2'b00);
`else
  assign misal_d = 1'b0;
`endif

  always_comb begin
    sh_d = mem_rdata >> {lo_q, 3'b000};
    ld_d = sh_d;
    case (size_q)
      2'd0:    ld_d = {24'd0, sh_d[7:0]};
      2'd1:    ld_d = {16'd0, sh_d[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      starve_cnt   <= '0;
      gnt_d_q      <= 1'b0;
      write_q      <= 1'b0;
      misal_q      <= 1'b0;
      lo_q         <= '0;
      size_q       <= '0;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_write    <= 1'b0;
      mem_byte_en  <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
      d_rsp_err    <= 1'b0;
    end else begin
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_write    <= 1'b0;
      mem_byte_en  <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
      d_rsp_err    <= 1'b0;

      if (if_acc)
        starve_cnt <= '0;
      else if (d_acc && if_req_valid && !starved)
        starve_cnt <= starve_cnt + 4'd1;

      case (state)
        IDLE, RESP: begin
          state <= IDLE;
          if (if_acc || d_acc) begin
            state   <= ISSUE;
            gnt_d_q <= d_acc;
            lo_q    <= req_addr[1:0];
            size_q  <= d_acc ? d_req_size : 2'd2;
            write_q <= d_acc && d_req_write;
            misal_q <= d_acc && misal_d;
            // Strobe and lanes are set up here so they are registered.
            if (!(d_acc && misal_d)) begin
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              if (d_acc && d_req_write) begin
                mem_write   <= 1'b1;
                mem_byte_en <= be_d;
                mem_wdata   <= wd_d;
              end
            end
          end
        end
        ISSUE: begin
          lat_cnt <= 3'(MEM_LAT);
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == 3'd1) begin
            state <= RESP;
            if (gnt_d_q) begin
              d_rsp_valid <= 1'b1;
              d_rsp_err   <= misal_q;
              d_rsp_data  <= (write_q || misal_q) ? 32'd0 : ld_d;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, MEM_LAT=2, STARVE_LIMIT=4.
// Expected strobes/responses are queued at grant and popped on output.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_write;
  logic [1:0]  d_req_size;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0BAD_F00D;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } mem_e_t;

  typedef struct {
    int          cyc;
    logic        is_d;
    logic [31:0] data;
    logic        err;
  } rsp_e_t;

  mem_e_t mem_q[$];
  rsp_e_t rsp_q[$];
  mem_e_t me;
  rsp_e_t re;
  rsp_e_t re_drop;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_word = 32'd0;
  logic        pend = 1'b0;
  logic        exp_ord [10];

  mem_port_arbiter #(
    .MEM_LAT(LAT),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req_valid(if_req_valid),
    .if_req_addr(if_req_addr),
    .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid),
    .d_req_addr(d_req_addr),
    .d_req_write(d_req_write),
    .d_req_size(d_req_size),
    .d_req_wdata(d_req_wdata),
    .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid),
    .d_rsp_data(d_rsp_data),
    .d_rsp_err(d_rsp_err),
    .mem_valid(mem_valid),
    .mem_addr(mem_addr),
    .mem_write(mem_write),
    .mem_byte_en(mem_byte_en),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns rd_word only in the cycle LAT after the strobe.
  always @(posedge clk) begin
    pend      <= mem_valid;
    mem_rdata <= pend ? rd_word : 32'h0BAD_F00D;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_valid === 1'b1) begin
      chk("mem_unexp", 32'(mem_q.size() > 0), 32'd1);
      if (mem_q.size() > 0) begin
        me = mem_q.pop_front();
        chk("mem_cyc", cyc, me.cyc);
        chk("mem_addr", mem_addr, me.addr);
        chk("mem_write", 32'(mem_write), 32'(me.we));
        chk("mem_be", 32'(mem_byte_en), 32'(me.be));
        if (me.we) chk("mem_wdata", mem_wdata, me.wd);
      end
    end
    if (if_rsp_valid === 1'b1 || d_rsp_valid === 1'b1) begin
      chk("rsp_unexp", 32'(rsp_q.size() > 0), 32'd1);
      if (rsp_q.size() > 0) begin
        re = rsp_q.pop_front();
        chk("rsp_cyc", cyc, re.cyc);
        chk("rsp_d", 32'(d_rsp_valid), 32'(re.is_d));
        chk("rsp_if", 32'(if_rsp_valid), 32'(!re.is_d));
        chk("rsp_data", re.is_d ? d_rsp_data : if_rsp_data, re.data);
        chk("rsp_err", 32'(d_rsp_err), 32'(re.err));
      end
    end
  end

  task automatic wait_grant(input bit is_d, output int t);
    t = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (is_d ? d_req_ready : if_req_ready) begin
        t = cyc;
        break;
      end
    end
    chk("grant_timeout", 32'(t >= 0), 32'd1);
  endtask

  task automatic f_req(input logic [31:0] a, input logic [31:0] ea,
                       input logic [31:0] ed);
    int t;
    if_req_valid = 1'b1;
    if_req_addr  = a;
    wait_grant(1'b0, t);
    if (t >= 0) begin
      mem_q.push_back('{t + 1, ea, 1'b0, 4'b0000, 32'd0});
      rsp_q.push_back('{t + 2 + LAT, 1'b0, ed, 1'b0});
    end
    @(posedge clk);
    #1;
    if_req_valid = 1'b0;
  endtask

  task automatic d_req(input logic [31:0] a, input logic w,
                       input logic [1:0] sz, input logic [31:0] wd,
                       input logic strobe, input logic [31:0] ea,
                       input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] ed, input logic eerr);
    int t;
    d_req_valid = 1'b1;
    d_req_addr  = a;
    d_req_write = w;
    d_req_size  = sz;
    d_req_wdata = wd;
    wait_grant(1'b1, t);
    if (t >= 0) begin
      if (strobe) mem_q.push_back('{t + 1, ea, w, ebe, ewd});
      rsp_q.push_back('{t + 2 + LAT, 1'b1, ed, eerr});
    end
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (mem_q.size() == 0 && rsp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain", 32'(mem_q.size() + rsp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({if_req_ready, d_req_ready, if_rsp_valid,
                            d_rsp_valid, d_rsp_err, mem_valid,
                            mem_write, mem_byte_en}), 32'd0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
    chk({tag, "_mwd"}, mem_wdata, 32'd0);
    chk({tag, "_ifd"}, if_rsp_data, 32'd0);
    chk({tag, "_dd"}, d_rsp_data, 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0;
    d_req_valid  = 1'b1;
    d_req_addr   = 32'h0;
    d_req_write  = 1'b0;
    d_req_size   = 2'd2;
    d_req_wdata  = 32'h0;
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst0");
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    rd_word = 32'hDEAD_BEEF;
    f_req(32'h104, 32'h104, 32'hDEAD_BEEF);
    drain();

    d_req(32'h1003, 1'b1, 2'd0, 32'h1234_56A5, 1'b1, 32'h1000,
          4'b1000, 32'hA5A5_A5A5, 32'd0, 1'b0);
    drain();
    d_req(32'h1006, 1'b1, 2'd1, 32'hFFFF_BEEF, 1'b1, 32'h1004,
          4'b1100, 32'hBEEF_BEEF, 32'd0, 1'b0);
    drain();
    d_req(32'h100C, 1'b1, 2'd2, 32'hCAFE_F00D, 1'b1, 32'h100C,
          4'b1111, 32'hCAFE_F00D, 32'd0, 1'b0);
    drain();

    rd_word = 32'h8001_1234;
    d_req(32'h2002, 1'b0, 2'd1, 32'h0, 1'b1, 32'h2000,
          4'b0000, 32'h0, 32'h0000_8001, 1'b0);
    drain();
    d_req(32'h2001, 1'b0, 2'd0, 32'h0, 1'b1, 32'h2000,
          4'b0000, 32'h0, 32'h0000_0012, 1'b0);
    drain();

    rd_word = 32'h1122_3344;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    d_req(32'h3001, 1'b0, 2'd2, 32'h0, 1'b0, 32'h0,
          4'b0000, 32'h0, 32'h0, 1'b1);
`else
    d_req(32'h3001, 1'b0, 2'd2, 32'h0, 1'b1, 32'h3000,
          4'b0000, 32'h0, 32'h0011_2233, 1'b0);
`endif
    drain();

    // Both sides held valid: data wins until the fetch is starved.
    rd_word      = 32'h600D_CAFE;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h200;
    d_req_valid  = 1'b1;
    d_req_addr   = 32'h400;
    d_req_write  = 1'b0;
    d_req_size   = 2'd2;
    for (int g = 0; g < 10; g++) begin
      int  t;
      logic got_d;
      t     = -1;
      got_d = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (if_req_ready || d_req_ready) begin
          t     = cyc;
          got_d = d_req_ready;
          break;
        end
      end
      chk($sformatf("sgrant%0d", g), 32'(t >= 0), 32'd1);
      chk($sformatf("onehot%0d", g),
          32'(if_req_ready & d_req_ready), 32'd0);
      chk($sformatf("order%0d", g), 32'(got_d), 32'(exp_ord[g]));
      if (t >= 0) begin
        mem_q.push_back('{t + 1, got_d ? 32'h400 : 32'h200,
                          1'b0, 4'b0000, 32'd0});
        rsp_q.push_back('{t + 2 + LAT, got_d, 32'h600D_CAFE, 1'b0});
      end
      @(posedge clk);
      #1;
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    drain();

    // Reset while a load sits in WAIT: its response must never appear.
    rd_word = 32'h7777_8888;
    d_req(32'h500, 1'b0, 2'd2, 32'h0, 1'b1, 32'h500,
          4'b0000, 32'h0, 32'h7777_8888, 1'b0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    re_drop = rsp_q.pop_back();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_zero("rst1");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rd_word = 32'h1357_9BDF;
    f_req(32'h0, 32'h0, 32'h1357_9BDF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
